div_gen: RTL and testbench

//  Multi-channel programmable integer clock divider for the single clk domain.

---
 rtl/div_gen.sv | 119 +++++++++++
 tb/tb_div_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_gen.sv
// Multi-channel programmable integer clock divider. Each channel runs its own
// phase counter; divisor and mode reload only at period boundaries or on sync.
`timescale 1ns/1ps
module div_gen #(
  parameter int WIDTH = 8,
  parameter int CH    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CH-1:0]         en,
  input  logic [CH*WIDTH-1:0]   div_i,
  input  logic [CH-1:0]         mode,
  input  logic                  sync,
  output logic [CH-1:0]         clk_o,
  output logic [CH-1:0]         tick,
  output logic [CH-1:0]         err
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Per-channel FSM state is kept in state_q so checkers can observe it directly.
  state_t [CH-1:0]            state_q, state_d;
  logic   [CH-1:0][WIDTH-1:0] cnt_q, cnt_d;
  logic   [CH-1:0][WIDTH-1:0] dact_q, dact_d;
  logic   [CH-1:0][WIDTH-1:0] div_c;
  logic   [CH-1:0][WIDTH-1:0] hi;
  logic   [CH-1:0]            mact_q, mact_d;
  logic   [CH-1:0]            legal;
  logic   [CH-1:0]            boundary;
  logic   [CH-1:0]            clk_d, tick_d, err_d;

  for (genvar g = 0; g < CH; g++) begin : g_slice
    assign div_c[g] = div_i[g*WIDTH +: WIDTH];
    assign legal[g] = (div_c[g] >= TWO);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dact_d   = dact_q;
    mact_d   = mact_q;
    err_d    = err;
    clk_d    = '0;
    tick_d   = '0;
    hi       = '0;
    boundary = '0;
    for (int c = 0; c < CH; c++) begin
      if (!en[c]) begin
        state_d[c] = S_IDLE;
        cnt_d[c]   = '0;
        err_d[c]   = 1'b0;
      end else begin
        case (state_q[c])
          S_IDLE: begin
            if (legal[c]) begin
              state_d[c] = S_RUN;
              dact_d[c]  = div_c[c];
              mact_d[c]  = mode[c];
              cnt_d[c]   = '0;
            end else begin
              err_d[c] = 1'b1;
            end
          end
          S_RUN: begin
            // dact_q is always >= 2 while running, so dact_q-1 cannot wrap.
            boundary[c] = sync || (cnt_q[c] == dact_q[c] - ONE);
            if (boundary[c]) begin
              cnt_d[c] = '0;
              if (legal[c]) begin
                dact_d[c] = div_c[c];
                mact_d[c] = mode[c];
              end else begin
                err_d[c] = 1'b1;
              end
            end else begin
              cnt_d[c] = cnt_q[c] + ONE;
            end
          end
          default: state_d[c] = S_IDLE;
        endcase
        if (state_d[c] == S_RUN) begin
          // Square output is high for ceil(n/2) cycles of each period.
          hi[c]     = dact_d[c] - (dact_d[c] >> 1);
          tick_d[c] = (cnt_d[c] == '0);
          clk_d[c]  = mact_d[c] ? (cnt_d[c] == '0) : (cnt_d[c] < hi[c]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < CH; c++) begin
        state_q[c] <= S_IDLE;
      end
      cnt_q  <= '0;
      dact_q <= '0;
      mact_q <= '0;
      clk_o  <= '0;
      tick   <= '0;
      err    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dact_q  <= dact_d;
      mact_q  <= mact_d;
      clk_o   <= clk_d;
      tick    <= tick_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_div_gen.sv
// Bench for div_gen: vector table, directed corner sequences and random
// stimulus checked against a period-level reference model.
`timescale 1ns/1ps
module tb_div_gen;
  localparam int WIDTH = 8;
  localparam int CH    = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [CH-1:0]       en, mode, clk_o, tick, err;
  logic [CH*WIDTH-1:0] div_i;
  logic                sync;

  int n_pass   = 0;
  int n_checks = 0;

  div_gen #(.WIDTH(WIDTH), .CH(CH)) dut (
    .clk(clk), .reset(reset), .en(en), .div_i(div_i), .mode(mode),
    .sync(sync), .clk_o(clk_o), .tick(tick), .err(err)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    n_checks++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // reference model: position within period, period length, output style
  int            m_act [CH];
  int            m_pos [CH];
  int            m_n   [CH];
  int            m_strb[CH];
  int            md;
  logic [CH-1:0] m_clk  = '0;
  logic [CH-1:0] m_tick = '0;
  logic [CH-1:0] m_err  = '0;

  initial begin
    for (int c = 0; c < CH; c++) begin
      m_act[c] = 0; m_pos[c] = 0; m_n[c] = 0; m_strb[c] = 0;
    end
  end

  always @(posedge clk) begin
    for (int c = 0; c < CH; c++) begin
      md = int'(div_i[c*WIDTH +: WIDTH]);
      if (!reset || !en[c]) begin
        m_act[c] = 0;
        m_err[c] = 1'b0;
      end else if (m_act[c] == 0 || sync || m_pos[c] == m_n[c] - 1) begin
        if (md >= 2) begin
          m_act[c] = 1; m_n[c] = md; m_strb[c] = int'(mode[c]); m_pos[c] = 0;
        end else begin
          m_err[c] = 1'b1;
          m_pos[c] = 0;
        end
      end else begin
        m_pos[c] = m_pos[c] + 1;
      end
      m_tick[c] = (m_act[c] != 0) && (m_pos[c] == 0);
      m_clk[c]  = (m_act[c] != 0) &&
                  ((m_strb[c] != 0) ? (m_pos[c] == 0) : (m_pos[c] < (m_n[c] + 1) / 2));
    end
  end

  // driver / checking tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_seq(input string name, input int ch, input logic [31:0] cp,
                         input logic [31:0] tp, input int len);
    for (int i = 0; i < len; i++) begin
      step();
      check($sformatf("%s clk_o[%0d] cyc%0d", name, ch, i), 32'(clk_o[ch]), 32'(cp[len-1-i]));
      check($sformatf("%s tick[%0d] cyc%0d", name, ch, i), 32'(tick[ch]), 32'(tp[len-1-i]));
    end
  endtask

  task automatic restart(input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                         input logic [CH-1:0] en_v);
    en = '0;
    step();
    div_i = {d1, d0};
    en    = en_v;
  endtask

  typedef struct {
    logic [WIDTH-1:0] div;
    logic             mode;
    logic [11:0]      exp_clk;
    logic [11:0]      exp_tick;
    logic             exp_err;
  } vec_t;

  vec_t vt[9];
  int   both;

  initial begin
    vt[0] = '{8'd2,   1'b0, 12'hAAA, 12'hAAA, 1'b0};
    vt[1] = '{8'd3,   1'b0, 12'hDB6, 12'h924, 1'b0};
    vt[2] = '{8'd4,   1'b0, 12'hCCC, 12'h888, 1'b0};
    vt[3] = '{8'd5,   1'b0, 12'hE73, 12'h842, 1'b0};
    vt[4] = '{8'd4,   1'b1, 12'h888, 12'h888, 1'b0};
    vt[5] = '{8'd3,   1'b1, 12'h924, 12'h924, 1'b0};
    vt[6] = '{8'd255, 1'b0, 12'hFFF, 12'h800, 1'b0};
    vt[7] = '{8'd1,   1'b0, 12'h000, 12'h000, 1'b1};
    vt[8] = '{8'd0,   1'b1, 12'h000, 12'h000, 1'b1};

    reset = 1'b0; en = 2'b11; div_i = {8'd4, 8'd4}; mode = '0; sync = 1'b0;

    // T1: reset holds everything low, then 1100 from the first edge after release
    for (int i = 0; i < 3; i++) begin
      step();
      check("t1 rst clk_o", 32'(clk_o), 32'd0);
      check("t1 rst tick",  32'(tick),  32'd0);
      check("t1 rst err",   32'(err),   32'd0);
    end
    reset = 1'b1;
    run_seq("t1", 0, 32'b11001100, 32'b10001000, 8);

    // vector table on channel 0 with channel 1 disabled
    for (int v = 0; v < 9; v++) begin
      en = '0;
      step();
      div_i[WIDTH-1:0] = vt[v].div;
      mode[0]          = vt[v].mode;
      en               = 2'b01;
      run_seq($sformatf("vec%0d", v), 0, 32'(vt[v].exp_clk), 32'(vt[v].exp_tick), 12);
      check($sformatf("vec%0d err", v), 32'(err[0]), 32'(vt[v].exp_err));
      check($sformatf("vec%0d ch1 idle", v), 32'({clk_o[1], tick[1]}), 32'd0);
    end
    mode = '0;

    // T2: div 5 square, then strobe from the next boundary
    restart(8'd5, 8'd5, 2'b11);
    run_seq("t2 sq", 0, 32'b1110011100, 32'b1000010000, 10);
    mode[0] = 1'b1;
    run_seq("t2 strobe", 0, 32'b1000010000, 32'b1000010000, 10);
    mode = '0;

    // T3: divisor change mid-period applies only after the current period
    restart(8'd4, 8'd4, 2'b11);
    run_seq("t3a", 0, 32'b11, 32'b10, 2);
    div_i[WIDTH-1:0] = 8'd6;
    run_seq("t3b", 0, 32'b00111000111000, 32'b00100000100000, 14);

    // T4: illegal start, illegal reload while running, clear on disable
    restart(8'd1, 8'd4, 2'b01);
    step();
    check("t4 start err", 32'(err[0]), 32'd1);
    run_seq("t4 idle", 0, 32'd0, 32'd0, 4);
    div_i[WIDTH-1:0] = 8'd3;
    run_seq("t4 run", 0, 32'b110, 32'b100, 3);
    check("t4 err sticky", 32'(err[0]), 32'd1);
    en = '0;
    step();
    check("t4 err clear", 32'(err[0]), 32'd0);
    en = 2'b01;
    run_seq("t4 run2", 0, 32'b110, 32'b100, 3);
    check("t4 err clean run", 32'(err[0]), 32'd0);
    div_i[WIDTH-1:0] = 8'd0;
    run_seq("t4 keep", 0, 32'b110110110, 32'b100100100, 9);
    check("t4 err reload", 32'(err[0]), 32'd1);
    en = '0;
    step();
    check("t4 err disable", 32'(err[0]), 32'd0);

    // T5: sync aligns channels of period 3 and 5; coincide again every 15
    restart(8'd3, 8'd5, 2'b01);
    step(); step();
    en = 2'b11;
    step(); step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("t5 sync tick", 32'(tick), 32'b11);
    check("t5 sync clk_o", 32'(clk_o), 32'b11);
    both = 0;
    for (int i = 1; i < 15; i++) begin
      step();
      if (tick == 2'b11) both++;
    end
    check("t5 no early coincidence", 32'(both), 32'd0);
    step();
    check("t5 coincide 15", 32'(tick), 32'b11);

    // T6: reset mid-period, restart at phase 0
    restart(8'd5, 8'd5, 2'b11);
    step(); step(); step();
    reset = 1'b0;
    step();
    check("t6 rst clk_o", 32'(clk_o), 32'd0);
    check("t6 rst tick",  32'(tick),  32'd0);
    check("t6 rst err",   32'(err),   32'd0);
    reset = 1'b1;
    run_seq("t6", 0, 32'b1110011100, 32'b1000010000, 10);

    // random stimulus against the reference model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 3) en[$urandom_range(0, CH-1)] ^= 1'b1;
      reset = ($urandom_range(0, 199) != 0);
      sync  = ($urandom_range(0, 29) == 0);
      mode  = CH'($urandom_range(0, 3));
      for (int c = 0; c < CH; c++) begin
        case ($urandom_range(0, 15))
          0:       div_i[c*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 1));
          1:       div_i[c*WIDTH +: WIDTH] = WIDTH'($urandom_range(2, 255));
          default: div_i[c*WIDTH +: WIDTH] = WIDTH'($urandom_range(2, 9));
        endcase
      end
      step();
      check($sformatf("rnd%0d clk_o", i), 32'(clk_o), 32'(m_clk));
      check($sformatf("rnd%0d tick", i),  32'(tick),  32'(m_tick));
      check($sformatf("rnd%0d err", i),   32'(err),   32'(m_err));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
